// File: rtl/seq_right_shifter_if.sv
// ----------------------------------------------------------------------------
// seq_right_shifter_if
// Request/response bundle between the execute controller and the iterative
// right shifter.
//   start          : request, only honoured while the shifter is idle
//   A              : operand to shift
//   B              : shift amount, full width (anything above 31 = full fill)
//   arith          : 1 = sign fill, 0 = zero fill
//   busy           : shifter is working on a request
//   done           : one-cycle pulse, RightShifted_A is valid
//   RightShifted_A : result, held until the next accepted request
// master = requester side, slave = shifter side.
// ----------------------------------------------------------------------------
interface seq_right_shifter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             arith;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] RightShifted_A;

  modport master (
    output start, A, B, arith,
    input  busy, done, RightShifted_A
  );

  modport slave (
    input  start, A, B, arith,
    output busy, done, RightShifted_A
  );
endinterface

// File: rtl/seq_right_shifter.sv
// ----------------------------------------------------------------------------
// seq_right_shifter
// Multi-cycle 32-bit logical/arithmetic right shifter. Operand A is shifted
// right by B, at most STEP bits per cycle, through a narrow internal shifter.
// Shift amounts above 31 saturate to a full fill (zeros or sign bits).
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-low reset
//   bus  : seq_right_shifter_if.slave (start/A/B/arith in, busy/done/result out)
//
// Parameters:
//   WIDTH : data width, only 32 is supported
//   STEP  : maximum shift per cycle, one of 1, 2, 4, 8
//
// Optional build macro RSHIFT_FASTPATH_EN: when defined, requests with B==0
// or B>31 bypass the SHIFT state and complete in the cycle after acceptance.
// When undefined, every request iterates and no bypass logic exists.
// ----------------------------------------------------------------------------
module seq_right_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input logic                clk,
  input logic                rst,
  seq_right_shifter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [5:0] STEP_AMT = 6'(STEP);
  localparam logic [5:0] FULL_AMT = 6'd32;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [5:0]       count_q, count_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [5:0]       step_k;

  // Per-cycle shift is min(count, STEP) so the last step never overshoots.
  always_comb begin
    step_k = (count_q > STEP_AMT) ? STEP_AMT : count_q;
  end

  // Next-state logic. Inputs are captured only on acceptance in IDLE; after
  // that the working register, count and sign carry the whole operation.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    count_d  = count_q;
    sign_d   = sign_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          work_d  = bus.A;
          sign_d  = bus.arith & bus.A[WIDTH-1];
          count_d = (|bus.B[WIDTH-1:5]) ? FULL_AMT : {1'b0, bus.B[4:0]};
          state_d = SHIFT;
`ifdef RSHIFT_FASTPATH_EN
          // Trivial amounts need no iteration: pass A through or emit the fill.
          if ((bus.B == '0) || (|bus.B[WIDTH-1:5])) begin
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = (bus.B == '0) ? bus.A
                                     : {WIDTH{bus.arith & bus.A[WIDTH-1]}};
          end
`endif
        end
      end

      SHIFT: begin
        if (count_q == 6'd0) begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = work_q;
        end else begin
          // Prepend STEP copies of the fill bit so vacated positions take sign.
          work_d  = WIDTH'({{STEP{sign_q}}, work_q} >> step_k);
          count_d = count_q - step_k;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      work_q   <= '0;
      count_q  <= 6'd0;
      sign_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      count_q  <= count_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.RightShifted_A = result_q;

endmodule

// File: tb/tb_seq_right_shifter.sv
// ----------------------------------------------------------------------------
// tb_seq_right_shifter
// Drives two shifter instances (STEP=1 and STEP=4) that share clock and
// reset, and compares result, completion cycle and handshake behaviour
// against hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_seq_right_shifter;

  logic clk;
  logic rst;

  seq_right_shifter_if #(.WIDTH(32)) bus0 ();
  seq_right_shifter_if #(.WIDTH(32)) bus1 ();

  seq_right_shifter #(.WIDTH(32), .STEP(1)) dut_step1 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  seq_right_shifter #(.WIDTH(32), .STEP(4)) dut_step4 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        arith;
    logic [31:0] exp_res;
    int          exp_cyc;
    string       name;
  } vec_t;

  vec_t vecs[13];
  int   checks;
  int   failures;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic start,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic arith);
    if (sel == 0) begin
      bus0.start = start; bus0.A = a; bus0.B = b; bus0.arith = arith;
    end else begin
      bus1.start = start; bus1.A = a; bus1.B = b; bus1.arith = arith;
    end
  endtask

  function automatic logic getDone(input int sel);
    return (sel == 0) ? bus0.done : bus1.done;
  endfunction

  function automatic logic getBusy(input int sel);
    return (sel == 0) ? bus0.busy : bus1.busy;
  endfunction

  function automatic logic [31:0] getRes(input int sel);
    return (sel == 0) ? bus0.RightShifted_A : bus1.RightShifted_A;
  endfunction

  // Expected completion cycle, accounting for the optional bypass.
  function automatic int expCycle(input logic [31:0] b, input int normal);
`ifdef RSHIFT_FASTPATH_EN
    if ((b == 32'd0) || (b > 32'd31)) return 1;
`endif
    return normal;
  endfunction

  initial begin
    int cyc;
    int busy_err;
    int pulses;

    checks   = 0;
    failures = 0;

    vecs[0]  = '{0, 32'hF0000000, 32'd4,        1'b0, 32'h0F000000, 6,  "s1_log_b4"};
    vecs[1]  = '{0, 32'hF0000000, 32'd4,        1'b1, 32'hFF000000, 6,  "s1_ari_b4"};
    vecs[2]  = '{0, 32'h80000000, 32'd40,       1'b1, 32'hFFFFFFFF, 34, "s1_ari_b40"};
    vecs[3]  = '{0, 32'h80000000, 32'd40,       1'b0, 32'h00000000, 34, "s1_log_b40"};
    vecs[4]  = '{1, 32'h12345678, 32'd7,        1'b0, 32'h002468AC, 4,  "s4_log_b7"};
    vecs[5]  = '{1, 32'h12345678, 32'd0,        1'b0, 32'h12345678, 2,  "s4_b0"};
    vecs[6]  = '{0, 32'h80000001, 32'd31,       1'b0, 32'h00000001, 33, "s1_log_b31"};
    vecs[7]  = '{0, 32'h80000000, 32'd31,       1'b1, 32'hFFFFFFFF, 33, "s1_ari_b31_neg"};
    vecs[8]  = '{0, 32'h7FFFFFFF, 32'd31,       1'b1, 32'h00000000, 33, "s1_ari_b31_pos"};
    vecs[9]  = '{1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 10, "s4_ari_bmax"};
    vecs[10] = '{1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000000, 10, "s4_log_bmax"};
    vecs[11] = '{1, 32'h87654321, 32'd13,       1'b1, 32'hFFFC3B2A, 6,  "s4_ari_b13"};
    vecs[12] = '{0, 32'h00000003, 32'd1,        1'b0, 32'h00000001, 3,  "s1_log_b1"};

    rst = 1'b0;
    applyStimulus(0, 1'b0, 32'd0, 32'd0, 1'b0);
    applyStimulus(1, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (3) @(negedge clk);

    checkOutput("reset_busy0", 32'(bus0.busy), 32'd0);
    checkOutput("reset_done0", 32'(bus0.done), 32'd0);
    checkOutput("reset_res0",  bus0.RightShifted_A, 32'd0);
    checkOutput("reset_busy1", 32'(bus1.busy), 32'd0);
    checkOutput("reset_done1", 32'(bus1.done), 32'd0);
    checkOutput("reset_res1",  bus1.RightShifted_A, 32'd0);

    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven vectors: inputs are scrambled right after acceptance.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].sel, 1'b1, vecs[i].a, vecs[i].b, vecs[i].arith);
      @(posedge clk);
      @(negedge clk);
      cyc = 1;
      applyStimulus(vecs[i].sel, 1'b0, ~vecs[i].a, ~vecs[i].b, ~vecs[i].arith);
      while (!getDone(vecs[i].sel) && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      checkOutput({vecs[i].name, "_cycle"}, 32'(cyc),
                  32'(expCycle(vecs[i].b, vecs[i].exp_cyc)));
      checkOutput({vecs[i].name, "_result"}, getRes(vecs[i].sel), vecs[i].exp_res);
      @(negedge clk);
      checkOutput({vecs[i].name, "_done_pulse"}, 32'(getDone(vecs[i].sel)), 32'd0);
      checkOutput({vecs[i].name, "_idle"}, 32'(getBusy(vecs[i].sel)), 32'd0);
      checkOutput({vecs[i].name, "_hold"}, getRes(vecs[i].sel), vecs[i].exp_res);
    end

    // Second start while busy must be ignored; busy covers cycles 1..done.
    @(negedge clk);
    applyStimulus(0, 1'b1, 32'h000000F0, 32'd3, 1'b0);
    @(posedge clk);
    @(negedge clk);
    cyc = 1;
    busy_err = 0;
    applyStimulus(0, 1'b0, 32'h000000F0, 32'd3, 1'b0);
    while (!getDone(0) && cyc < 100) begin
      if (!getBusy(0)) busy_err++;
      if (cyc == 2) applyStimulus(0, 1'b1, 32'hFFFFFFFF, 32'd1, 1'b1);
      else if (cyc == 3) applyStimulus(0, 1'b0, 32'hFFFFFFFF, 32'd1, 1'b1);
      @(negedge clk);
      cyc++;
    end
    if (!getBusy(0)) busy_err++;
    checkOutput("ignore_cycle", 32'(cyc), 32'd5);
    checkOutput("ignore_result", getRes(0), 32'h0000001E);
    checkOutput("ignore_busy_span", 32'(busy_err), 32'd0);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (getDone(0)) pulses++;
    end
    checkOutput("ignore_no_second_done", 32'(pulses), 32'd0);
    checkOutput("ignore_idle", 32'(getBusy(0)), 32'd0);

    // Asynchronous reset in cycle 5 of a B=20 operation.
    @(negedge clk);
    applyStimulus(0, 1'b1, 32'hFFFF0000, 32'd20, 1'b0);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("prereset_busy", 32'(bus0.busy), 32'd1);
    #1 rst = 1'b0;
    #1;
    checkOutput("async_rst_busy", 32'(bus0.busy), 32'd0);
    checkOutput("async_rst_done", 32'(bus0.done), 32'd0);
    checkOutput("async_rst_res",  bus0.RightShifted_A, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus0.done || bus0.busy) pulses++;
    end
    checkOutput("post_rst_quiet", 32'(pulses), 32'd0);

    // Back-to-back with start held: B=1 then B=2, one IDLE cycle between.
    @(negedge clk);
    applyStimulus(0, 1'b1, 32'h80000000, 32'd1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    cyc = 1;
    while (!getDone(0) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("b2b_first_cycle", 32'(cyc), 32'd3);
    checkOutput("b2b_first_result", getRes(0), 32'hC0000000);
    applyStimulus(0, 1'b1, 32'h00000010, 32'd2, 1'b0);
    @(negedge clk);
    cyc++;
    checkOutput("b2b_idle_busy", 32'(getBusy(0)), 32'd0);
    checkOutput("b2b_idle_done", 32'(getDone(0)), 32'd0);
    @(negedge clk);
    cyc++;
    while (!getDone(0) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("b2b_second_cycle", 32'(cyc), 32'd8);
    checkOutput("b2b_second_result", getRes(0), 32'h00000004);
    @(negedge clk);
    checkOutput("b2b_trailing_idle", 32'(getBusy(0)), 32'd0);
    checkOutput("b2b_trailing_done", 32'(getDone(0)), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
